// File: rtl/gam_pattern_sequencer_if.sv
// Bus bundle between the pattern sequencer and its controller / memory layer.
// The controller drives the table writes, control pulses and recall queries. The sequencer drives x/c and the status flags.
interface gam_pattern_sequencer_if #(
  parameter int unsigned CLASS_COUNT = 4,
  parameter int unsigned NODE_COUNT  = 5,
  parameter int unsigned VEC_W       = 128
);
  localparam int unsigned CW = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
  localparam int unsigned NW = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;

  logic             wr_en;
  logic [CW-1:0]    wr_class;
  logic [NW-1:0]    wr_node;
  logic [VEC_W-1:0] wr_data;
  logic             clear;
  logic             start;
  logic             stop;
  logic             q_valid;
  logic [VEC_W-1:0] q_data;
  logic             q_ready;
  logic [VEC_W-1:0] x;
  logic [31:0]      c;
  logic             learning_done;
  logic             learning_recall;
  logic             busy;

  modport master (
    output wr_en, wr_class, wr_node, wr_data, clear, start, stop, q_valid, q_data,
    input  q_ready, x, c, learning_done, learning_recall, busy
  );

  modport slave (
    input  wr_en, wr_class, wr_node, wr_data, clear, start, stop, q_valid, q_data,
    output q_ready, x, c, learning_done, learning_recall, busy
  );
endinterface

// File: rtl/gam_pattern_sequencer.sv
// Replays a table of training patterns to the memory layer and then forwards recall queries.
// Every output is registered, so each value appears on the cycle after the event that causes it.
module gam_pattern_sequencer #(
  parameter int unsigned CLASS_COUNT   = 4,
  parameter int unsigned NODE_COUNT    = 5,
  parameter int unsigned VEC_W         = 128,
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned RECALL_CYCLES = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  gam_pattern_sequencer_if.slave  bus
);
  localparam int unsigned TOTAL = CLASS_COUNT * NODE_COUNT;
  localparam int unsigned IDXW  = $clog2(TOTAL + 1);
  localparam int unsigned MAXH  = (HOLD_CYCLES > RECALL_CYCLES) ? HOLD_CYCLES : RECALL_CYCLES;
  localparam int unsigned CNTW  = $clog2(MAXH + 1);
  localparam logic [IDXW-1:0] NONE = IDXW'(TOTAL);

  typedef enum logic [1:0] {S_IDLE, S_LEARN, S_RECALL_RDY, S_RECALL_HOLD} state_t;

  state_t           r_state;
  logic [VEC_W-1:0] r_mem [TOTAL];
  logic [TOTAL-1:0] r_valid;
  logic [IDXW-1:0]  r_idx;
  logic [CNTW-1:0]  r_cnt;
  logic [VEC_W-1:0] r_x;
  logic [31:0]      r_c;
  logic             r_done;
  logic             r_lr;
  logic             r_qready;
  logic             r_busy;

  logic             w_wr_ok;
  logic [IDXW-1:0]  w_wr_idx;
  logic [TOTAL-1:0] w_valid_eff;
  logic [IDXW-1:0]  w_first;
  logic [IDXW-1:0]  w_next;
  logic [VEC_W-1:0] w_first_data;

  // Lowest valid flat index >= s (class-major order), or NONE.
  function automatic logic [IDXW-1:0] f_next(input logic [TOTAL-1:0] v, input logic [IDXW-1:0] s);
    logic [IDXW-1:0] r;
    r = NONE;
    for (int unsigned i = TOTAL; i > 0; i--) begin
      if (v[i-1] && (IDXW'(i - 1) >= s)) r = IDXW'(i - 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] f_class(input logic [IDXW-1:0] idx);
    return 32'(idx) / NODE_COUNT + 32'd1;
  endfunction

  always_comb begin
    w_wr_ok  = (r_state == S_IDLE) && bus.wr_en &&
               (32'(bus.wr_class) < CLASS_COUNT) && (32'(bus.wr_node) < NODE_COUNT);
    w_wr_idx = IDXW'(32'(bus.wr_class) * NODE_COUNT + 32'(bus.wr_node));
    // Clear is applied before a same-cycle write, so the written slot stays valid.
    w_valid_eff = bus.clear ? '0 : r_valid;
    if (w_wr_ok) w_valid_eff[w_wr_idx] = 1'b1;
    w_first      = f_next(w_valid_eff, '0);
    w_next       = f_next(r_valid, r_idx + IDXW'(1));
    w_first_data = (w_wr_ok && (w_first == w_wr_idx)) ? bus.wr_data : r_mem[w_first];
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_wr_idx] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_x      <= '0;
      r_c      <= '0;
      r_done   <= 1'b1;
      r_lr     <= 1'b0;
      r_qready <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= w_valid_eff;
          if (bus.start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (w_first != NONE) begin
              r_state <= S_LEARN;
              r_idx   <= w_first;
              r_x     <= w_first_data;
              r_c     <= f_class(w_first);
              r_done  <= 1'b0;
            end else begin
              r_state  <= S_RECALL_RDY;
              r_done   <= 1'b1;
              r_lr     <= 1'b1;
              r_qready <= 1'b1;
            end
          end
        end
        S_LEARN: begin
          if (r_cnt == CNTW'(HOLD_CYCLES - 1)) begin
            r_cnt <= '0;
            if (w_next != NONE) begin
              r_idx <= w_next;
              r_x   <= r_mem[w_next];
              r_c   <= f_class(w_next);
            end else begin
              r_state  <= S_RECALL_RDY;
              r_done   <= 1'b1;
              r_lr     <= 1'b1;
              r_qready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        S_RECALL_RDY, S_RECALL_HOLD: begin
          if (bus.stop) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_done   <= 1'b1;
            r_lr     <= 1'b0;
            r_qready <= 1'b0;
            r_busy   <= 1'b0;
          end else if (r_state == S_RECALL_RDY) begin
            if (bus.q_valid) begin
              r_state  <= S_RECALL_HOLD;
              r_x      <= bus.q_data;
              r_qready <= 1'b0;
              r_cnt    <= '0;
            end
          end else if (r_cnt == CNTW'(RECALL_CYCLES - 1)) begin
            r_state  <= S_RECALL_RDY;
            r_qready <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.x               = r_x;
  assign bus.c               = r_c;
  assign bus.learning_done   = r_done;
  assign bus.learning_recall = r_lr;
  assign bus.q_ready         = r_qready;
  assign bus.busy            = r_busy;
endmodule

// File: tb/tb_gam_pattern_sequencer.sv
// Directed bench for gam_pattern_sequencer: learning passes, recall handshake, stop, clear and reset.
module tb_gam_pattern_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [127:0] SPARSE = {32'd54, 32'd54754654, 32'd32432432, 32'd675656};

  gam_pattern_sequencer_if #(.CLASS_COUNT(4), .NODE_COUNT(5), .VEC_W(128)) bus ();

  gam_pattern_sequencer #(
    .CLASS_COUNT(4), .NODE_COUNT(5), .VEC_W(128), .HOLD_CYCLES(10), .RECALL_CYCLES(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int cls, input int node, input logic [127:0] d);
    bus.wr_en    = 1'b1;
    bus.wr_class = 2'(cls);
    bus.wr_node  = 3'(node);
    bus.wr_data  = d;
    tick();
    bus.wr_en    = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, bus.x, 128'd0);
    chk({tag, "_c"}, 128'(bus.c), 128'd0);
    chk({tag, "_done"}, 128'(bus.learning_done), 128'd1);
    chk({tag, "_lr"}, 128'(bus.learning_recall), 128'd0);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, "_qready"}, 128'(bus.q_ready), 128'd0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_class = '0; bus.wr_node = '0; bus.wr_data = '0;
    bus.clear = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.q_valid = 1'b0; bus.q_data = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outputs("por");

    // Basic pass, with a start pulse mid-pass that must not restart it
    wr(0, 0, 128'd1234);
    wr(0, 1, 128'd22313);
    wr(0, 2, 128'd324234);
    bus.start = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      chk($sformatf("basic_x_c%0d", k), bus.x,
          (k <= 10) ? 128'd1234 : (k <= 20) ? 128'd22313 : 128'd324234);
      chk($sformatf("basic_c_c%0d", k), 128'(bus.c), 128'd1);
      chk($sformatf("basic_done_c%0d", k), 128'(bus.learning_done), 128'd0);
      chk($sformatf("basic_busy_c%0d", k), 128'(bus.busy), 128'd1);
      bus.start = (k == 5);
      tick();
    end
    bus.start = 1'b0;
    chk("basic_end_done", 128'(bus.learning_done), 128'd1);
    chk("basic_end_lr", 128'(bus.learning_recall), 128'd1);
    chk("basic_end_qready", 128'(bus.q_ready), 128'd1);
    chk("basic_end_x_kept", bus.x, 128'd324234);

    // Recall handshake; q_valid stays high during the hold with other data
    bus.q_valid = 1'b1;
    bus.q_data  = 128'd1234;
    tick();
    bus.q_data  = 128'd999;
    for (int j = 1; j <= 10; j++) begin
      chk($sformatf("recall_x_%0d", j), bus.x, 128'd1234);
      chk($sformatf("recall_qready_%0d", j), 128'(bus.q_ready), 128'd0);
      tick();
    end
    bus.q_valid = 1'b0;
    chk("recall_qready_back", 128'(bus.q_ready), 128'd1);
    chk("recall_x_not_retaken", bus.x, 128'd1234);

    // stop beats a same-cycle query
    bus.stop = 1'b1; bus.q_valid = 1'b1; bus.q_data = 128'd555;
    tick();
    bus.stop = 1'b0; bus.q_valid = 1'b0;
    chk("stop_lr", 128'(bus.learning_recall), 128'd0);
    chk("stop_busy", 128'(bus.busy), 128'd0);
    chk("stop_qready", 128'(bus.q_ready), 128'd0);
    chk("stop_done", 128'(bus.learning_done), 128'd1);
    chk("stop_x_no_query", bus.x, 128'd1234);

    // Sparse table: invalid slots skipped with no gap
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    wr(0, 4, 128'd123);
    wr(2, 0, SPARSE);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("sparse_x_c%0d", k), bus.x, (k <= 10) ? 128'd123 : SPARSE);
      chk($sformatf("sparse_c_c%0d", k), 128'(bus.c), (k <= 10) ? 128'd1 : 128'd3);
      tick();
    end
    chk("sparse_end_qready", 128'(bus.q_ready), 128'd1);
    chk("sparse_end_lr", 128'(bus.learning_recall), 128'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // clear+write together, out-of-range node ignored, write visible to same-cycle start
    bus.clear = 1'b1;
    wr(1, 1, 128'd77);
    bus.clear = 1'b0;
    wr(0, 5, 128'd88);
    bus.start = 1'b1;
    wr(3, 4, 128'd4444);
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("bound_x_c%0d", k), bus.x, (k <= 10) ? 128'd77 : 128'd4444);
      chk($sformatf("bound_c_c%0d", k), 128'(bus.c), (k <= 10) ? 128'd2 : 128'd4);
      tick();
    end
    chk("bound_end_qready", 128'(bus.q_ready), 128'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // Second pass replays the stored table; reset lands mid-LEARN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("replay_x", bus.x, 128'd77);
    chk("replay_c", 128'(bus.c), 128'd2);
    chk("replay_done", 128'(bus.learning_done), 128'd0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("midlearn_rst");
    tick();
    reset = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("empty_qready", 128'(bus.q_ready), 128'd1);
    chk("empty_lr", 128'(bus.learning_recall), 128'd1);
    chk("empty_done", 128'(bus.learning_done), 128'd1);
    chk("empty_busy", 128'(bus.busy), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
